mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_mem_addr_gen.sv | 30 +++
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Purpose: shared types and constants for the data-memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

  // Highest valid data-memory address; the memory is ADDR_MAX+1 bytes deep.
  localparam int unsigned ADDR_MAX_DEFAULT = 32;

  // Pointer addressing modes. Code 2'b11 is reserved and behaves as direct.
  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_POSTINC = 2'b01;
  localparam logic [1:0] MODE_PREDEC  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_FIN,
    ST_ERR
  } state_e;

  // Only the auto-modify modes write a new pointer value back to the core.
  function automatic logic mode_updates_ptr(input logic [1:0] mode);
    return (mode == MODE_POSTINC) || (mode == MODE_PREDEC);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_mem_addr_gen.sv
// Purpose: effective address, next pointer and range check for one access.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mode_i/ptr_i in; eff_addr_o, next_ptr_o, range_err_o out.
module mem_addr_gen
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_MAX = ADDR_MAX_DEFAULT
) (
  input  logic [1:0] mode_i,
  input  logic [7:0] ptr_i,
  output logic [7:0] eff_addr_o,
  output logic [7:0] next_ptr_o,
  output logic       range_err_o
);

  logic [7:0] ptr_inc;
  logic [7:0] ptr_dec;

  always_comb begin
    // Both wrap modulo 256, so pre-decrement of 0x00 lands on 0xFF.
    ptr_inc     = ptr_i + 8'd1;
    ptr_dec     = ptr_i - 8'd1;
    eff_addr_o  = (mode_i == MODE_PREDEC) ? ptr_dec : ptr_i;
    // Only meaningful for post-inc/pre-dec; direct and reserved ignore it.
    next_ptr_o  = (mode_i == MODE_PREDEC) ? ptr_dec : ptr_inc;
    range_err_o = (32'(eff_addr_o) > ADDR_MAX);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: sequences one core load/store at a time onto a registered data memory.
// Latency: request edge to done_o = 3 cycles (load), 2 (store); range error pulses err_o after 2.
// Backpressure: none; req_i is only sampled in IDLE, requests while busy_o are dropped.
// Ports: clk_i/rst_ni; core side req_i, we_i, mode_i, ptr_i, wdata_i -> busy_o, done_o,
//        err_o, rdata_o, ptr_o, ptr_we_o; memory side mem_e_o, mem_we_o, mem_addr_o,
//        mem_di_o, mem_do_i.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_MAX = ADDR_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] ptr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [7:0] ptr_o,
  output logic       ptr_we_o,
  output logic       mem_e_o,
  output logic       mem_we_o,
  output logic [7:0] mem_addr_o,
  output logic [7:0] mem_di_o,
  input  logic [7:0] mem_do_i
);

  logic [7:0] gen_addr;
  logic [7:0] gen_nptr;
  logic       gen_err;

  mem_addr_gen #(
    .ADDR_MAX (ADDR_MAX)
  ) u_addr_gen (
    .mode_i      (mode_i),
    .ptr_i       (ptr_i),
    .eff_addr_o  (gen_addr),
    .next_ptr_o  (gen_nptr),
    .range_err_o (gen_err)
  );

  state_e     state_q,    state_d;
  logic [7:0] addr_q,     addr_d;
  logic [7:0] wdata_q,    wdata_d;
  logic [7:0] nptr_q,     nptr_d;
  logic       upd_q,      upd_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;
  logic [7:0] rdata_q,    rdata_d;
  logic [7:0] ptr_out_q,  ptr_out_d;
  logic       ptr_we_q,   ptr_we_d;
  logic       mem_e_q,    mem_e_d;
  logic       mem_we_q,   mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_di_q,   mem_di_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nptr_d  = nptr_q;
    upd_d   = upd_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = gen_addr;
          wdata_d = wdata_i;
          nptr_d  = gen_nptr;
          upd_d   = mode_updates_ptr(mode_i);
          if (gen_err) begin
            state_d = ST_ERR;
          end else if (we_i) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        // Memory output is registered: the byte addressed in RD_ADDR is valid now.
        rdata_d = mem_do_i;
        state_d = ST_FIN;
      end
      ST_WR:   state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);
    err_d      = (state_q == ST_ERR);
    ptr_we_d   = (state_d == ST_FIN) && upd_d;
    ptr_out_d  = ptr_we_d ? nptr_d : ptr_out_q;
    mem_e_d    = (state_d == ST_RD_ADDR) || (state_d == ST_RD_DATA);
    mem_we_d   = (state_d == ST_WR);
    mem_addr_d = (mem_e_d || mem_we_d) ? addr_d : 8'h00;
    mem_di_d   = mem_we_d ? wdata_d : 8'h00;
  end

  // Async reset clears the strobes immediately, abandoning any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      nptr_q     <= 8'h00;
      upd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'h00;
      ptr_out_q  <= 8'h00;
      ptr_we_q   <= 1'b0;
      mem_e_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 8'h00;
      mem_di_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nptr_q     <= nptr_d;
      upd_q      <= upd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ptr_out_q  <= ptr_out_d;
      ptr_we_q   <= ptr_we_d;
      mem_e_q    <= mem_e_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_di_q   <= mem_di_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign ptr_o      = ptr_out_q;
  assign ptr_we_o   = ptr_we_q;
  assign mem_e_o    = mem_e_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_di_o   = mem_di_q;

endmodule
